// File: rtl/data_mem_resp_pkg.sv
// Shared constants and types for the data-memory responder.
// Holds bus widths, reset/chip-enable levels and the FSM state encoding
// used by data_mem_resp and its interface.
package data_mem_resp_pkg;

  localparam logic        RstEnable   = 1'b1;
  localparam logic        RstDisable  = 1'b0;
  localparam logic        ChipEnable  = 1'b1;
  localparam logic        ChipDisable = 1'b0;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

  localparam int DataBus     = 32;
  localparam int DataAddrBus = 32;
  localparam int ByteSelBus  = 4;

  // Wait-state counter width; WAIT_CYCLES is limited to 0..15.
  localparam int CntW = 4;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/data_mem_resp_if.sv
// Memory-stage load/store port between the pipeline (master) and the
// data-memory responder (slave).
//   mem_ce_i/we_i/addr_i/sel_i/data_i : request, driven by the master
//   mem_data_o/ack_o/stallreq_o       : response, driven by the slave
//   mem_err_o                         : error completion, only when the
//                                       DATA_MEM_ERR_EN macro is defined
interface data_mem_resp_if;
  import data_mem_resp_pkg::*;

  logic                   mem_ce_i;
  logic                   mem_we_i;
  logic [DataAddrBus-1:0] mem_addr_i;
  logic [ByteSelBus-1:0]  mem_sel_i;
  logic [DataBus-1:0]     mem_data_i;
  logic [DataBus-1:0]     mem_data_o;
  logic                   mem_ack_o;
  logic                   stallreq_o;
`ifdef DATA_MEM_ERR_EN
  logic                   mem_err_o;

  modport master (
    output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    input  mem_data_o, mem_ack_o, stallreq_o, mem_err_o
  );

  modport slave (
    input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    output mem_data_o, mem_ack_o, stallreq_o, mem_err_o
  );
`else
  modport master (
    output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    input  mem_data_o, mem_ack_o, stallreq_o
  );

  modport slave (
    input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    output mem_data_o, mem_ack_o, stallreq_o
  );
`endif

endinterface

// File: rtl/data_mem_resp_array.sv
// data_mem_array: synchronous word RAM with byte-lane write enables.
// One write port, one read port with registered read data. No control logic.
//   clk     : clock
//   we      : write enable
//   wr_addr : write word index
//   wr_sel  : byte-lane enables, bit k covers wr_data[8k+7:8k]
//   wr_data : write data
//   rd_addr : read word index
//   rd_data : registered read data (old contents on a same-edge write)
module data_mem_array
  import data_mem_resp_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [ByteSelBus-1:0] wr_sel,
  input  logic [DataBus-1:0]    wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DataBus-1:0]    rd_data
);

  logic [DataBus-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < ByteSelBus; k++) begin
        if (wr_sel[k]) begin
          mem[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
        end
      end
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: data-memory responder for the memory-stage load/store port.
// Captures one word-addressed request in IDLE, waits WAIT_CYCLES wait
// states, then completes with a one-cycle ack. Stores commit their enabled
// byte lanes at the completion edge; the ack carries the pre-write word.
//   clk, rst : clock, synchronous active-high reset
//   bus      : data_mem_resp_if slave modport (request in, response out)
// Optional feature macro: DATA_MEM_ERR_EN adds mem_err_o, which replaces
// the ack for misaligned full-word or out-of-range accesses.
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  data_mem_resp_if.slave bus
);

  localparam logic [CntW-1:0] WaitLoad = WAIT_CYCLES[CntW-1:0];

  dmem_state_e           state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  capture;

  logic                  we_q;
  logic [ADDR_W-1:0]     idx_q;
  logic [ByteSelBus-1:0] sel_q;
  logic [DataBus-1:0]    wdata_q;

  logic [ADDR_W-1:0]     in_idx;
  logic [ADDR_W-1:0]     rd_addr;
  logic [DataBus-1:0]    rd_data;
  logic                  resp_live;
  logic                  ack;
  logic                  wr_en;

  assign in_idx = bus.mem_addr_i[ADDR_W+1:2];

`ifdef DATA_MEM_ERR_EN
  logic req_err;
  logic err_q;

  assign req_err = ((bus.mem_addr_i[1:0] != 2'b00) && (bus.mem_sel_i == 4'b1111))
                 || (|bus.mem_addr_i[DataAddrBus-1:ADDR_W+2]);
`else
  // Upper and byte-offset address bits are deliberately dropped here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.mem_addr_i[DataAddrBus-1:ADDR_W+2], bus.mem_addr_i[1:0]};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      DMEM_IDLE: begin
        if (bus.mem_ce_i == ChipEnable) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = DMEM_RESP;
          end else begin
            state_d = DMEM_WAIT;
            cnt_d   = WaitLoad;
          end
        end
      end
      DMEM_WAIT: begin
        if (bus.mem_ce_i == ChipDisable) begin
          // Master withdrew the request: drop it silently.
          state_d = DMEM_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == 4'd1) begin
            state_d = DMEM_RESP;
          end
        end
      end
      DMEM_RESP: begin
        state_d = DMEM_IDLE;
      end
      default: begin
        state_d = DMEM_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      sel_q   <= '0;
      wdata_q <= ZeroWord;
`ifdef DATA_MEM_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        we_q    <= bus.mem_we_i;
        idx_q   <= in_idx;
        sel_q   <= bus.mem_sel_i;
        wdata_q <= bus.mem_data_i;
`ifdef DATA_MEM_ERR_EN
        err_q   <= req_err;
`endif
      end
    end
  end

  // In IDLE the RAM reads at the incoming index so a zero-wait access has
  // its word ready in RESP; afterwards it keeps reading the captured index.
  assign rd_addr = (state_q == DMEM_IDLE) ? in_idx : idx_q;

  // A reset asserted during RESP kills both the ack and the write.
  assign resp_live = (state_q == DMEM_RESP) && (rst != RstEnable);

`ifdef DATA_MEM_ERR_EN
  assign ack            = resp_live && !err_q;
  assign bus.mem_err_o  = resp_live && err_q;
  assign bus.stallreq_o = bus.mem_ce_i && !(ack || bus.mem_err_o);
`else
  assign ack            = resp_live;
  assign bus.stallreq_o = bus.mem_ce_i && !ack;
`endif

  assign bus.mem_ack_o  = ack;
  assign bus.mem_data_o = ack ? rd_data : ZeroWord;
  assign wr_en          = ack && we_q;

  data_mem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .we      (wr_en),
    .wr_addr (idx_q),
    .wr_sel  (sel_q),
    .wr_data (wdata_q),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: doc/data_mem_resp.md
Name: data_mem_resp

Overview:
- Data-memory responder on the far side of the pipeline's memory-stage load/store port.
- Accepts one word-addressed request at a time from the memory stage over a ce/ack handshake and applies byte-lane writes.
- Returns read data after a programmable number of wait states.
- Raises a stall request to the pipeline controller while an access is outstanding.

Parameters:
- ADDR_W, 10, word-address width; memory holds 2**ADDR_W 32-bit words
- WAIT_CYCLES, 2, wait states between capture and ack (0..15)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- mem_ce_i  in  1  request valid; held by master until ack
- mem_we_i  in  1  1 = store, 0 = load
- mem_addr_i  in  32  byte address; bits [ADDR_W+1:2] index the word
- mem_sel_i  in  4  byte-lane enables; bit k covers data[8k+7:8k]
- mem_data_i  in  32  store data
- mem_data_o  out  32  load data, valid only while mem_ack_o=1
- mem_ack_o  out  1  one-cycle completion pulse
- stallreq_o  out  1  pipeline stall request

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: FSM returns to IDLE and the wait counter clears to 0. The reset values are mem_ack_o=0, mem_data_o=0 and stallreq_o=0. Memory contents are not cleared.
- FSM states are IDLE, WAIT and RESP.
  - IDLE: if mem_ce_i=1, capture we, word index, sel and data; load counter with WAIT_CYCLES. Go to WAIT, or go straight to RESP when WAIT_CYCLES=0.
  - WAIT: decrement the counter. Go to RESP when the counter reaches 1.
  - RESP: mem_ack_o=1 for exactly one cycle, then return to IDLE.
- Latency: a request first seen in IDLE at cycle N produces ack at cycle N+1+WAIT_CYCLES.
- Store commit:
  - Lanes with sel[k]=1 are written at the RESP clock edge, using the captured data. Other lanes are unchanged.
  - mem_data_o during a store ack is the pre-write word.
- Load: mem_data_o shows the full word read at the captured index during RESP. sel does not mask it; masking and sign extension belong to the pipeline.
- Outside RESP, mem_data_o=0.
- stallreq_o = mem_ce_i AND NOT mem_ack_o. It is combinational, so it is high in the request cycle and low in the ack cycle.
- Abort: if mem_ce_i drops while in WAIT, return to IDLE on the next edge with no write and no ack.
- Address:
  - Bits above ADDR_W+1 are ignored, so the address wraps modulo the memory size.
  - Bits [1:0] are ignored.
- Back-to-back: the RESP cycle never captures a new request. A request held high through ack is sampled again in IDLE on the following cycle, so the master must drop mem_ce_i in the ack cycle or accept a repeat.
- Reset in WAIT or RESP aborts the access with no write and no ack.
- Inputs are sampled only in IDLE. Changes during WAIT are ignored, except for the mem_ce_i abort.

Optional Feature:
- Macro: DATA_MEM_ERR_EN.
- When defined, an extra output mem_err_o (1 bit, reset 0) is added. An access is in error when either:
  - mem_addr_i[1:0]!=0 and mem_sel_i=4'b1111, or
  - any of address bits [31:ADDR_W+2] is nonzero.
- An errored access follows the normal latency, but the completion cycle asserts mem_err_o=1 instead of mem_ack_o. No write occurs and mem_data_o=0.
- stallreq_o deasserts in that cycle.
- When undefined, the port is absent and such accesses wrap or ignore bits as described above.

Decomposition:
- Shared defines file, alongside the existing RstEnable/ZeroWord constants:
  - DataBus (32), DataAddrBus (32), ByteSelBus (4)
  - FSM state encodings DMEM_IDLE/DMEM_WAIT/DMEM_RESP
  - ChipEnable/ChipDisable
- One sub-module, data_mem_array: a synchronous byte-lane-writable word RAM. It has one write port and one read port (read data registered) and holds no control logic.

Test Plan:
- WAIT_CYCLES=2: store addr 0x10, sel 4'b1111, data 0xDEADBEEF at cycle 5 → ack at cycle 8, stallreq_o high in cycles 5–7. A load of 0x10 then returns 0xDEADBEEF.
- Byte-lane store 0x000000AA, sel 4'b0001, to addr 0x10 holding 0xDEADBEEF → a later load returns 0xDEADBEAA.
- Abort: start a store to 0x20 (word 0x11111111 present), drop ce after 1 cycle → no ack, and a load returns 0x11111111.
- WAIT_CYCLES=0: load request at cycle N → ack at N+1. Hold ce through ack → second ack at N+3.
- Wrap: store 0xCAFEF00D to addr 0x1000 with ADDR_W=10 → a load of addr 0x0 returns 0xCAFEF00D.
- Reset in WAIT during a store → no write and no ack, outputs are 0 the cycle after reset. With DATA_MEM_ERR_EN, a load of addr 0x12 with sel 4'b1111 gives mem_err_o=1 and mem_ack_o=0.
